morse_keyer_ctrl: RTL and testbench
===================================

Name: morse_keyer_ctrl

Overview:
- Sequences the single debounced Morse key into complete symbols.
- Times each key press and classifies it as a dot or a dash.
- Times the gaps between presses to find letter and word boundaries, and packs the elements into a symbol word.
- Hands each symbol to the downstream decoder/display over a valid/ready handshake. Sits between the key debouncer and the Morse-to-character lookup.

Parameters:
- CNT_W, 8, width of the duration counter; saturates at 2^CNT_W-1.
- DOT_MAX, 3, press of fewer than DOT_MAX ticks is a dot; DOT_MAX or more is a dash.
- LETTER_GAP, 3, key-up ticks that end a letter.
- WORD_GAP, 7, total key-up ticks (counted from the last release) that end a word; WORD_GAP > LETTER_GAP.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle timing enable (time unit); all durations are counted in ticks.
- key  in  1  debounced key level, 1 = pressed.
- out_valid  out  1  symbol available.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_bits  out  5  elements; bit i = element i, 0 = dot, 1 = dash, first element in bit 0; unused bits 0.
- out_len  out  3  element count 0..5.
- out_space  out  1  1 = word-space symbol (out_len = 0, out_bits = 0).
- err  out  1  one-cycle pulse on element overflow or a press lost during a stall.

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; counter 0; buffer cleared; key_q = 0. Reset asserted mid-operation discards any partial symbol immediately.
- Edge detect: key_q is key registered. rise = key & ~key_q; fall = ~key & key_q.
- Counter rules:
  - cnt increments on tick and saturates.
  - Every decision uses the registered cnt value before that cycle's increment.
  - cnt clears to 0 on every state transition listed below.
- IDLE: rise -> PRESS.
- PRESS, on fall:
  - Element = (cnt >= DOT_MAX).
  - If len < 5: store element at bit len, len++.
  - If len == 5: drop the element and pulse err.
  - Go to LGAP.
- LGAP:
  - rise -> PRESS; rise wins over a simultaneous threshold.
  - Else cnt == LETTER_GAP -> EMIT_L.
- EMIT_L:
  - out_valid = 1, out_bits/out_len = buffer, out_space = 0. Outputs are held stable until accepted.
  - cnt keeps counting key-up time while key = 0.
  - On accept: clear the buffer.
    - key = 1 -> PRESS with cnt = 0.
    - Else -> WGAP, keeping cnt.
- WGAP:
  - rise -> PRESS.
  - cnt + LETTER_GAP >= WORD_GAP -> EMIT_W. Equivalently, the word threshold is WORD_GAP total from the release; the implementation may keep one total gap counter.
- EMIT_W:
  - out_valid = 1, out_space = 1, len/bits = 0.
  - On accept: key = 1 -> PRESS; else -> IDLE.
  - At most one space is emitted per gap. No space is emitted before the first letter, because IDLE is never reached from reset via a space.
- Stall rules, in EMIT_* with out_ready = 0:
  - A key rise followed by a fall while still stalled means the press is lost: pulse err on the fall.
  - A rise with key still high at accept is timed from accept.
- Handshake:
  - out_valid never deasserts without accept.
  - The next out_valid comes at least 1 cycle after accept, never back-to-back.
- Latency: LETTER_GAP ticks after the last release, plus 1 clk, to out_valid.

Decomposition:
- morse_pkg:
  - state enum (IDLE, PRESS, LGAP, EMIT_L, WGAP, EMIT_W);
  - MAX_ELEMS = 5; ELEM_DOT = 0, ELEM_DASH = 1;
  - LEN_W = 3.
- One sub-module: morse_dur_counter, a CNT_W saturating tick counter with synchronous clear and async reset, instantiated once.

Test Plan:
Common settings for all scenarios: DOT_MAX = 3, LETTER_GAP = 3, WORD_GAP = 7, tick every 4 clk, out_ready = 1 unless stated.
- Letter 'A': press 1 tick, up 1, press 5, release, up 3 -> one out_valid with out_len = 2, out_bits = 5'b00010, out_space = 0, err = 0.
- Word space: continue 'A' with key up 4 more ticks -> second out_valid with out_space = 1, out_len = 0. Holding up 50 more ticks -> no further out_valid.
- Boundaries: press exactly 3 ticks -> dash. Up exactly 2 ticks then press 1 -> same letter. Result: out_len = 2, out_bits = 5'b00001.
- Overflow: 6 dots with 1-tick gaps -> err pulses once on the 6th release. Emit out_len = 5, out_bits = 5'b00000.
- Backpressure: hold out_ready = 0 for 40 clk after 'A' -> outputs stable.
  - A full 1-tick press inside the stall -> err pulse.
  - A press still held at accept -> next letter starts with that element.
- Reset mid-PRESS: drop rst_n for 2 clk during a press -> all outputs 0 asynchronously. After release and 10 ticks up -> no out_valid.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse keyer controller.
//   state_e   : sequencer states
//   MAX_ELEMS : element capacity of one symbol
//   LEN_W     : width of the element count
//   ELEM_*    : element encoding in the symbol word
package morse_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPress,
        StLgap,
        StEmitL,
        StWgap,
        StEmitW
    } state_e;

    localparam int unsigned MAX_ELEMS = 5;
    localparam int unsigned LEN_W     = 3;

    localparam logic ELEM_DOT  = 1'b0;
    localparam logic ELEM_DASH = 1'b1;

endpackage

// File: rtl/morse_dur_counter.sv
// Saturating duration counter used to time key presses and gaps.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear (wins over inc_i)
//   inc_i      : count enable, one time unit per assertion
//   cnt_o      : current count, saturates at all-ones
module morse_dur_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/morse_keyer_ctrl.sv
// Morse keyer controller: times key presses into dots/dashes, finds letter and
// word boundaries from key-up time, and hands out one symbol per boundary over
// a valid/ready handshake.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   tick_i       : one-cycle time-unit enable
//   key_i        : debounced key level, 1 = pressed
//   out_valid_o  : symbol available, held until accepted
//   out_ready_i  : consumer ready
//   out_bits_o   : elements, bit i = element i, 1 = dash
//   out_len_o    : element count
//   out_space_o  : word-space symbol
//   err_o        : one-cycle pulse on element overflow or press lost in a stall
module morse_keyer_ctrl
    import morse_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned DOT_MAX    = 3,
    parameter int unsigned LETTER_GAP = 3,
    parameter int unsigned WORD_GAP   = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_i,
    input  logic                 key_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [MAX_ELEMS-1:0] out_bits_o,
    output logic [LEN_W-1:0]     out_len_o,
    output logic                 out_space_o,
    output logic                 err_o
);

    localparam logic [CNT_W-1:0] DotMaxC    = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] LetterGapC = CNT_W'(LETTER_GAP);
    // The counter restarts at the letter boundary, so the word threshold is the
    // remainder of the total gap.
    localparam logic [CNT_W-1:0] WordRemC   = CNT_W'(WORD_GAP - LETTER_GAP);
    localparam logic [LEN_W-1:0] MaxLenC    = LEN_W'(MAX_ELEMS);

    state_e               state_q, state_d;
    logic                 key_q;
    logic [MAX_ELEMS-1:0] buf_q, buf_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 valid_q, valid_d;
    logic [MAX_ELEMS-1:0] bits_q, bits_d;
    logic [LEN_W-1:0]     olen_q, olen_d;
    logic                 space_q, space_d;
    logic                 err_q, err_d;

    logic             rise, fall, accept;
    logic             cnt_clr, cnt_inc;
    logic [CNT_W-1:0] cnt;

    morse_dur_counter #(
        .CNT_W (CNT_W)
    ) u_dur_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .cnt_o (cnt)
    );

    assign rise   = key_i & ~key_q;
    assign fall   = ~key_i & key_q;
    assign accept = valid_q & out_ready_i;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        len_d   = len_q;
        valid_d = valid_q;
        bits_d  = bits_q;
        olen_d  = olen_q;
        space_d = space_q;
        err_d   = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = tick_i;

        case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StPress;
                    cnt_clr = 1'b1;
                end
            end

            StPress: begin
                if (fall) begin
                    if (len_q < MaxLenC) begin
                        buf_d[len_q] = (cnt >= DotMaxC) ? ELEM_DASH : ELEM_DOT;
                        len_d        = len_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = StLgap;
                    cnt_clr = 1'b1;
                end
            end

            StLgap: begin
                if (rise) begin
                    state_d = StPress;
                    cnt_clr = 1'b1;
                end else if (cnt == LetterGapC) begin
                    state_d = StEmitL;
                    cnt_clr = 1'b1;
                    valid_d = 1'b1;
                    bits_d  = buf_q;
                    olen_d  = len_q;
                    space_d = 1'b0;
                end
            end

            StEmitL: begin
                // Keep timing the gap so the word boundary still lands WORD_GAP
                // after the release even when the consumer stalls.
                cnt_inc = tick_i & ~key_i;
                // Key was low on entry, so any release here is a press that
                // began and ended inside the stall.
                if (fall) begin
                    err_d = 1'b1;
                end
                if (accept) begin
                    valid_d = 1'b0;
                    bits_d  = '0;
                    olen_d  = '0;
                    buf_d   = '0;
                    len_d   = '0;
                    if (key_i) begin
                        state_d = StPress;
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = StWgap;
                    end
                end
            end

            StWgap: begin
                if (rise) begin
                    state_d = StPress;
                    cnt_clr = 1'b1;
                end else if (cnt >= WordRemC) begin
                    state_d = StEmitW;
                    cnt_clr = 1'b1;
                    valid_d = 1'b1;
                    bits_d  = '0;
                    olen_d  = '0;
                    space_d = 1'b1;
                end
            end

            StEmitW: begin
                if (fall) begin
                    err_d = 1'b1;
                end
                if (accept) begin
                    valid_d = 1'b0;
                    space_d = 1'b0;
                    state_d = key_i ? StPress : StIdle;
                    cnt_clr = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            key_q   <= 1'b0;
            buf_q   <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            bits_q  <= '0;
            olen_q  <= '0;
            space_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_i;
            buf_q   <= buf_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            bits_q  <= bits_d;
            olen_q  <= olen_d;
            space_q <= space_d;
            err_q   <= err_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_bits_o  = bits_q;
    assign out_len_o   = olen_q;
    assign out_space_o = space_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_morse_keyer_ctrl.sv
module tb_morse_keyer_ctrl;

    typedef struct packed {
        logic [4:0] bits;
        logic [2:0] len;
        logic       space;
    } sym_t;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       key;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_bits;
    logic [2:0] out_len;
    logic       out_space;
    logic       err;

    int total = 0;
    int bad = 0;
    int rx_count = 0;
    int err_count = 0;
    int tick_count = 0;
    logic [1:0] div = 2'd0;
    sym_t exp_q[$];

    morse_keyer_ctrl #(
        .CNT_W      (8),
        .DOT_MAX    (3),
        .LETTER_GAP (3),
        .WORD_GAP   (7)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_i      (tick),
        .key_i       (key),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_bits_o  (out_bits),
        .out_len_o   (out_len),
        .out_space_o (out_space),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One tick every 4 clocks; tick_count counts ticks the DUT has seen.
    assign tick = (div == 2'd3);
    always @(posedge clk) begin
        div <= div + 2'd1;
        if (tick) tick_count <= tick_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int target;
        target = tick_count + n;
        while (tick_count < target) @(negedge clk);
    endtask

    task automatic press(input int n);
        key = 1'b1;
        wait_ticks(n);
        key = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int n;
        n = 0;
        while (!out_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic push(input logic [4:0] b, input logic [2:0] l, input logic s);
        sym_t e;
        e.bits  = b;
        e.len   = l;
        e.space = s;
        exp_q.push_back(e);
    endtask

    // Scoreboard: compare every accepted symbol with the next expected one.
    always @(negedge clk) begin
        sym_t e;
        if (err) err_count++;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sym_bits", 32'(out_bits), 32'(e.bits));
                check("sym_len", 32'(out_len), 32'(e.len));
                check("sym_space", 32'(out_space), 32'(e.space));
                rx_count++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        rst_n = 1'b0;
        key = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_bits", 32'(out_bits), 32'd0);
        check("rst_len", 32'(out_len), 32'd0);
        check("rst_space", 32'(out_space), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        wait_ticks(2);
        check("idle_valid", 32'(out_valid), 32'd0);

        // Letter 'A' (dot, dash) followed by a word space, then a long silence.
        push(5'b00010, 3'd2, 1'b0);
        push(5'b00000, 3'd0, 1'b1);
        press(1);
        wait_ticks(1);
        press(5);
        wait_ticks(3);
        wait_ticks(4);
        check("a_letter_rx", 32'(rx_count), 32'd1);
        wait_ticks(50);
        check("a_space_rx", 32'(rx_count), 32'd2);
        check("a_q_empty", 32'(exp_q.size()), 32'd0);
        check("a_no_err", 32'(err_count), 32'd0);

        // Boundaries: 3-tick press is a dash, 2-tick gap stays in the letter.
        push(5'b00001, 3'd2, 1'b0);
        push(5'b00000, 3'd0, 1'b1);
        press(3);
        wait_ticks(2);
        press(1);
        wait_ticks(17);
        check("bnd_rx", 32'(rx_count), 32'd4);
        check("bnd_q_empty", 32'(exp_q.size()), 32'd0);

        // Overflow: sixth dot dropped with one err pulse.
        push(5'b00000, 3'd5, 1'b0);
        push(5'b00000, 3'd0, 1'b1);
        e0 = err_count;
        repeat (5) begin
            press(1);
            wait_ticks(1);
        end
        check("ovf_no_early_err", 32'(err_count), 32'(e0));
        press(1);
        wait_ticks(1);
        check("ovf_err", 32'(err_count), 32'(e0 + 1));
        wait_ticks(16);
        check("ovf_rx", 32'(rx_count), 32'd6);
        check("ovf_err_once", 32'(err_count), 32'(e0 + 1));

        // Backpressure on 'A': outputs held, lost press flagged, held press kept.
        out_ready = 1'b0;
        push(5'b00010, 3'd2, 1'b0);
        press(1);
        wait_ticks(1);
        press(5);
        wait_ticks(3);
        wait_valid("bp_valid", 8);
        repeat (5) begin
            repeat (8) @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_bits", 32'(out_bits), 32'd2);
            check("bp_hold_len", 32'(out_len), 32'd2);
        end
        wait_ticks(1);
        e0 = err_count;
        press(1);
        wait_ticks(1);
        check("bp_lost_err", 32'(err_count), 32'(e0 + 1));
        check("bp_still_valid", 32'(out_valid), 32'd1);
        push(5'b00001, 3'd1, 1'b0);
        push(5'b00000, 3'd0, 1'b1);
        key = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        wait_ticks(5);
        key = 1'b0;
        wait_ticks(17);
        check("bp_rx", 32'(rx_count), 32'd9);
        check("bp_q_empty", 32'(exp_q.size()), 32'd0);
        check("bp_err_total", 32'(err_count), 32'(e0 + 1));

        // Reset while a symbol is pending: outputs drop without a clock edge.
        out_ready = 1'b0;
        press(1);
        wait_ticks(3);
        wait_valid("rst_pend_valid", 8);
        #3 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_len", 32'(out_len), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        rst_n = 1'b1;
        wait_ticks(10);
        check("rst_pend_rx", 32'(rx_count), 32'd9);

        // Reset mid-press discards the partial letter.
        press(1);
        wait_ticks(1);
        key = 1'b1;
        wait_ticks(1);
        #3 rst_n = 1'b0;
        #1;
        check("rstp_valid", 32'(out_valid), 32'd0);
        check("rstp_bits", 32'(out_bits), 32'd0);
        check("rstp_len", 32'(out_len), 32'd0);
        check("rstp_space", 32'(out_space), 32'd0);
        check("rstp_err", 32'(err), 32'd0);
        @(negedge clk);
        key = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(10);
        check("rstp_rx", 32'(rx_count), 32'd9);
        check("rstp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
